pb_conditioner: RTL and testbench
=================================

PB_CONDITIONER -- requirements
Module: pb_conditioner

Interface
REQ-001 SHALL have parameter CNT_W, default 16: debounce counter width; a level must hold for 2^CNT_W cycles to be accepted.
REQ-002 SHALL have parameter REP_DLY, default 32'd5000000: cycles of continuous hold before the first auto-repeat pulse.
REQ-003 SHALL have parameter REP_PER, default 32'd1000000: cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have port CLK, input, 1: single clock; all flops on its posedge.
REQ-005 SHALL have port RST, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port PB, input, 1: raw asynchronous push-button level, active-low (pressed = 0).
REQ-007 SHALL have port PB_state, output, 1: debounced level, 1 = pressed.
REQ-008 SHALL have port PB_down, output, 1: one-cycle pulse on accepted press.
REQ-009 SHALL have port PB_up, output, 1: one-cycle pulse on accepted release.
REQ-010 SHALL have port PB_rep, output, 1: one-cycle auto-repeat strobe.

Function
REQ-011 SHALL pass PB through a two-flop synchronizer; only the second flop output (sync) feeds the logic.
REQ-012 SHALL compare ~sync with PB_state each cycle; equal -> counter cleared to 0.
REQ-013 SHALL increment the counter by 1 each cycle of mismatch; at count == 2^CNT_W-1 with mismatch, toggle PB_state and clear the counter (no wrap).
REQ-014 SHALL update PB_state on edge N+1+2^CNT_W when PB changes before edge N and is stable afterwards.
REQ-015 SHALL treat a single-cycle return to agreement as a glitch: counter cleared, filtering restarts from 0.
REQ-016 SHALL assert PB_down (PB_up) for exactly the cycle after PB_state goes 0->1 (1->0); never both at once.
REQ-017 SHALL keep a repeat FSM with states IDLE, DELAY, REPEAT and a 32-bit timer.
REQ-018 SHALL go IDLE->DELAY on PB_down, clear the timer, and assert PB_rep coincident with PB_down.
REQ-019 SHALL go DELAY->REPEAT when the timer reaches REP_DLY-1, pulse PB_rep, clear the timer.
REQ-020 SHALL pulse PB_rep in REPEAT every REP_PER cycles (timer reaches REP_PER-1, then cleared).
REQ-021 SHALL return any state to IDLE in the cycle PB_state is 0; no PB_rep is issued in that cycle.
REQ-022 SHALL give release priority when release and a timer expiry coincide: PB_up=1, PB_rep=0.

Reset
REQ-023 SHALL, while RST=1 at a CLK edge, set the synchronizer flops to 1 (released), counter 0, PB_state 0, PB_down/PB_up/PB_rep 0, FSM IDLE, timer 0.
REQ-024 SHALL, if reset is asserted mid-filter or mid-repeat, abort without emitting PB_up.
REQ-025 SHALL, with the button held through reset, report the press only after the full filter time following RST release, then emit PB_down.

Configuration
REQ-026 SHALL compile the repeat FSM, timer and PB_rep logic only when macro PB_CONDITIONER_REPEAT_EN is defined.
REQ-027 SHALL, without PB_CONDITIONER_REPEAT_EN, keep port PB_rep present and tied to 0, with all other behaviour unchanged.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/DELAY/REPEAT) and default REP_DLY/REP_PER constants in shared package pb_conditioner_pkg.
REQ-029 SHALL implement the two-flop synchronizer as sub-module sync_2ff (reset value parameterised).

Verification (CNT_W=3, REP_DLY=20, REP_PER=5)
REQ-030 SHALL check: PB 1->0 clean at edge N -> PB_state=1 and PB_down pulse at edge N+9; no other pulses.
REQ-031 SHALL check: PB bounces 0/1 every 3 cycles for 40 cycles then steady 1 -> PB_state stays 0, no pulses.
REQ-032 SHALL check: press held 60 cycles after accept, repeat enabled -> PB_rep at accept, accept+20, +25, +30 ... +55; release -> PB_up, PB_rep stops.
REQ-033 SHALL check: release accepted in the same cycle a REP_PER expiry is due -> PB_up=1, PB_rep=0.
REQ-034 SHALL check: RST pulsed while PB_state=1 -> all outputs 0 next cycle, no PB_up; PB still 0 -> PB_down 9 cycles after RST drops.
REQ-035 SHALL check: build without PB_CONDITIONER_REPEAT_EN, 60-cycle hold -> PB_rep constantly 0, PB_down/PB_up identical to the enabled build.

Source files
------------

// File: rtl/pb_conditioner_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package pb_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  localparam logic [31:0] REP_DLY_DEFAULT = 32'd5000000;
  localparam logic [31:0] REP_PER_DEFAULT = 32'd1000000;

endpackage

// File: rtl/pb_conditioner_sync.sv
// Two-flop synchronizer for an asynchronous level; reset value is a parameter.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pb_conditioner.sv
// Push-button debouncer with press/release pulses and optional auto-repeat.
// Auto-repeat is built only when PB_CONDITIONER_REPEAT_EN is defined; otherwise PB_rep is 0.
module pb_conditioner
  import pb_conditioner_pkg::*;
#(
  parameter int          CNT_W   = 16,
  parameter logic [31:0] REP_DLY = REP_DLY_DEFAULT,
  parameter logic [31:0] REP_PER = REP_PER_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic PB,
  output logic PB_state,
  output logic PB_down,
  output logic PB_up,
  output logic PB_rep
);

  logic             sync;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic             expire;
  logic             press_evt;
  logic             release_evt;
  logic             state_nxt;

  // Synchronizer resets to 1 so a released button is the idle level.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (PB),
    .q   (sync)
  );

  assign mismatch    = (~sync) != PB_state;
  assign expire      = mismatch && (cnt == {CNT_W{1'b1}});
  assign press_evt   = expire && !PB_state;
  assign release_evt = expire && PB_state;
  assign state_nxt   = PB_state ^ expire;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      PB_state <= 1'b0;
      PB_down  <= 1'b0;
      PB_up    <= 1'b0;
    end else begin
      if (!mismatch || expire) cnt <= '0;
      else                     cnt <= cnt + 1'b1;
      PB_state <= state_nxt;
      PB_down  <= press_evt;
      PB_up    <= release_evt;
    end
  end

`ifdef PB_CONDITIONER_REPEAT_EN
  rep_state_t  rep_state;
  rep_state_t  rep_state_nxt;
  logic [31:0] timer;
  logic [31:0] timer_nxt;
  logic        rep_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rep_state <= IDLE;
      timer     <= '0;
      PB_rep    <= 1'b0;
    end else begin
      rep_state <= rep_state_nxt;
      timer     <= timer_nxt;
      PB_rep    <= rep_nxt;
    end
  end

  // Looking at state_nxt lets a coincident release win over a timer expiry.
  always_comb begin
    rep_state_nxt = rep_state;
    if (!state_nxt) begin
      rep_state_nxt = IDLE;
    end else begin
      case (rep_state)
        IDLE:    if (press_evt) rep_state_nxt = DELAY;
        DELAY:   if (timer == REP_DLY - 32'd1) rep_state_nxt = REPEAT;
        REPEAT:  rep_state_nxt = REPEAT;
        default: rep_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    timer_nxt = timer + 32'd1;
    rep_nxt   = 1'b0;
    if (!state_nxt) begin
      timer_nxt = '0;
    end else begin
      case (rep_state)
        IDLE: begin
          timer_nxt = '0;
          rep_nxt   = press_evt;
        end
        DELAY: begin
          if (timer == REP_DLY - 32'd1) begin
            timer_nxt = '0;
            rep_nxt   = 1'b1;
          end
        end
        REPEAT: begin
          if (timer == REP_PER - 32'd1) begin
            timer_nxt = '0;
            rep_nxt   = 1'b1;
          end
        end
        default: timer_nxt = '0;
      endcase
    end
  end
`else
  logic unused_rep_cfg;
  assign unused_rep_cfg = ^{REP_DLY, REP_PER};
  assign PB_rep         = 1'b0;
`endif

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with CNT_W=3, REP_DLY=20, REP_PER=5.
module tb_pb_conditioner;

`ifdef PB_CONDITIONER_REPEAT_EN
  localparam logic REP_EN = 1'b1;
`else
  localparam logic REP_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic pb;
  logic pb_state;
  logic pb_down;
  logic pb_up;
  logic pb_rep;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic        exp_rep;

  pb_conditioner #(
    .CNT_W   (3),
    .REP_DLY (32'd20),
    .REP_PER (32'd5)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .PB       (pb),
    .PB_state (pb_state),
    .PB_down  (pb_down),
    .PB_up    (pb_up),
    .PB_rep   (pb_rep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic e_state, input logic e_down,
                       input logic e_up, input logic e_rep);
    total++;
    assert (pb_state === e_state) else begin
      bad++;
      $error("FAIL %s PB_state: observed=%0b expected=%0b", tag, pb_state, e_state);
    end
    total++;
    assert (pb_down === e_down) else begin
      bad++;
      $error("FAIL %s PB_down: observed=%0b expected=%0b", tag, pb_down, e_down);
    end
    total++;
    assert (pb_up === e_up) else begin
      bad++;
      $error("FAIL %s PB_up: observed=%0b expected=%0b", tag, pb_up, e_up);
    end
    total++;
    assert (pb_rep === e_rep) else begin
      bad++;
      $error("FAIL %s PB_rep: observed=%0b expected=%0b", tag, pb_rep, e_rep);
    end
  endtask

  // n cycles with a steady debounced level and no pulses of any kind
  task automatic quiet(input int n, input logic e_state, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, e_state, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    pb  = 1'b1;
    tick();
    tick();
    check("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    quiet(4, 1'b0, "idle");

    // Clean press: accepted 9 edges after the input changes.
    pb = 1'b0;
    quiet(9, 1'b0, "press_filter");
    tick();
    check("press_accept", 1'b1, 1'b1, 1'b0, REP_EN);

    // Hold: repeats at +20 then every 5; release lands on the +60 expiry.
    exp_q = {32'd20, 32'd25, 32'd30, 32'd35, 32'd40, 32'd45, 32'd50, 32'd55};
    for (int k = 1; k <= 59; k++) begin
      tick();
      exp_rep = 1'b0;
      if (exp_q.size() > 0 && exp_q[0] == k) begin
        exp_rep = REP_EN;
        void'(exp_q.pop_front());
      end
      check("hold", 1'b1, 1'b0, 1'b0, exp_rep);
      if (k == 50) pb = 1'b1;
    end
    tick();
    check("release_vs_repeat", 1'b0, 1'b0, 1'b1, 1'b0);
    quiet(10, 1'b0, "after_release");

    // Bounce every 3 cycles never reaches the filter length.
    for (int i = 0; i < 40; i++) begin
      pb = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      check("bounce", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    pb = 1'b1;
    quiet(12, 1'b0, "bounce_settle");

    // One-cycle glitch just before acceptance restarts the filter.
    pb = 1'b0;
    quiet(7, 1'b0, "glitch_pre");
    pb = 1'b1;
    quiet(1, 1'b0, "glitch");
    pb = 1'b0;
    quiet(9, 1'b0, "glitch_restart");
    tick();
    check("glitch_accept", 1'b1, 1'b1, 1'b0, REP_EN);

    // Reset while pressed: no PB_up, press re-reported after a full filter.
    quiet(3, 1'b1, "pre_reset");
    rst = 1'b1;
    tick();
    check("reset_abort", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    quiet(9, 1'b0, "held_through_reset");
    tick();
    check("reaccept", 1'b1, 1'b1, 1'b0, REP_EN);

    pb = 1'b1;
    quiet(9, 1'b1, "release_filter");
    tick();
    check("release_accept", 1'b0, 1'b0, 1'b1, 1'b0);
    quiet(3, 1'b0, "end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
